s4ga_cfg_sequencer: RTL and testbench

//  Owns the S4GA LUT-config stream. A host loads one frame of config segments
//  (N LUTs x LL segments) into an external 1R/1W RAM. The block then holds the

---
 rtl/s4ga_cfg_sequencer_if.sv | 26 ++
 rtl/s4ga_cfg_sequencer.sv | 175 +++++++++++++++++
 tb/tb_s4ga_cfg_sequencer.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/s4ga_cfg_sequencer_if.sv
// Host load port and external 1R/1W config RAM port of the S4GA config sequencer.
interface s4ga_cfg_sequencer_if #(
    parameter int unsigned SI_W = 4,
    parameter int unsigned A_W  = 13
) ();
    logic            ld_valid;
    logic            ld_ready;
    logic [SI_W-1:0] ld_data;
    logic            ld_last;
    logic            mem_we;
    logic [A_W-1:0]  mem_addr;
    logic [SI_W-1:0] mem_wdata;
    logic [SI_W-1:0] mem_rdata;

    // Host + RAM side
    modport master (
        output ld_valid, ld_data, ld_last, mem_rdata,
        input  ld_ready, mem_we, mem_addr, mem_wdata
    );

    // Sequencer side
    modport slave (
        input  ld_valid, ld_data, ld_last, mem_rdata,
        output ld_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/s4ga_cfg_sequencer.sv
// S4GA LUT-config sequencer: loads one frame into external RAM, holds the fabric in
// reset, then replays the frame forever. Optional run-length limit: S4GA_SEQ_FRAMES_EN.
module s4ga_cfg_sequencer #(
    parameter int unsigned SI_W       = 4,
    parameter int unsigned FRAME_SEGS = 6509,
    parameter int unsigned RST_CYCLES = 300,
    parameter int unsigned A_W        = 13
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load_req,
    input  logic            start,
    input  logic            stop,
`ifdef S4GA_SEQ_FRAMES_EN
    input  logic [15:0]     frame_limit,
`endif
    s4ga_cfg_sequencer_if.slave bus,
    output logic [SI_W-1:0] si,
    output logic            fab_rst,
    output logic            frame_sync,
    output logic            loaded,
    output logic            err,
    output logic [1:0]      state,
    output logic [15:0]     frame_cnt
);
    localparam int unsigned RC_W = $clog2(RST_CYCLES + 1);
    localparam logic [A_W-1:0] LAST = A_W'(FRAME_SEGS - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, LOAD = 2'd1, FRST = 2'd2, RUN = 2'd3} state_t;

    state_t          st, st_n;
    logic [A_W-1:0]  wptr, wptr_n;
    logic [RC_W-1:0] rcnt, rcnt_n;
    logic [A_W-1:0]  seg, seg_n;
    logic            stop_pend, stop_pend_n;
    logic            ld_ready_n, mem_we_n;
    logic [A_W-1:0]  mem_addr_n;
    logic [SI_W-1:0] mem_wdata_n, si_n;
    logic            fab_rst_n, frame_sync_n, loaded_n, err_n;
    logic [15:0]     frame_cnt_n;
    logic [15:0]     limit, limit_n;
    logic            limit_hit;

    function automatic logic [A_W-1:0] addr_inc(input logic [A_W-1:0] a);
        return (a == LAST) ? '0 : a + A_W'(1);
    endfunction

    assign state = st;

`ifdef S4GA_SEQ_FRAMES_EN
    // Counter already includes the frame on si, so end when it equals the limit
    assign limit_hit = (limit != 16'd0) && (frame_cnt == limit);
`else
    assign limit_hit = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            st            <= IDLE;
            wptr          <= '0;
            rcnt          <= '0;
            seg           <= '0;
            stop_pend     <= 1'b0;
            limit         <= '0;
            bus.ld_ready  <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            si            <= '0;
            fab_rst       <= 1'b1;
            frame_sync    <= 1'b0;
            loaded        <= 1'b0;
            err           <= 1'b0;
            frame_cnt     <= '0;
        end else begin
            st            <= st_n;
            wptr          <= wptr_n;
            rcnt          <= rcnt_n;
            seg           <= seg_n;
            stop_pend     <= stop_pend_n;
            limit         <= limit_n;
            bus.ld_ready  <= ld_ready_n;
            bus.mem_we    <= mem_we_n;
            bus.mem_addr  <= mem_addr_n;
            bus.mem_wdata <= mem_wdata_n;
            si            <= si_n;
            fab_rst       <= fab_rst_n;
            frame_sync    <= frame_sync_n;
            loaded        <= loaded_n;
            err           <= err_n;
            frame_cnt     <= frame_cnt_n;
        end
    end

    always_comb begin
        st_n         = st;
        wptr_n       = wptr;
        rcnt_n       = rcnt;
        seg_n        = seg;
        stop_pend_n  = stop_pend;
        limit_n      = limit;
        mem_we_n     = 1'b0;
        mem_addr_n   = bus.mem_addr;
        mem_wdata_n  = bus.mem_wdata;
        loaded_n     = loaded;
        err_n        = err;
        frame_cnt_n  = frame_cnt;

        case (st)
            IDLE: begin
                if (load_req) begin
                    st_n     = LOAD;
                    wptr_n   = '0;
                    loaded_n = 1'b0;
                end else if (start) begin
                    if (loaded) begin
                        st_n        = FRST;
                        rcnt_n      = RC_W'(RST_CYCLES - 1);
                        frame_cnt_n = '0;
                        stop_pend_n = 1'b0;
                        mem_addr_n  = '0;
`ifdef S4GA_SEQ_FRAMES_EN
                        limit_n     = frame_limit;
`endif
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end
            LOAD: begin
                if (bus.ld_valid && bus.ld_ready) begin
                    mem_we_n    = 1'b1;
                    mem_addr_n  = wptr;
                    mem_wdata_n = bus.ld_data;
                    wptr_n      = wptr + A_W'(1);
                    if (bus.ld_last) begin
                        st_n = IDLE;
                        if (wptr == LAST) loaded_n = 1'b1;
                        else              err_n    = 1'b1;
                    end else if (wptr == LAST) begin
                        st_n  = IDLE;
                        err_n = 1'b1;
                    end
                end
            end
            FRST: begin
                // Address 0 sits on the RAM two cycles before RUN to cover RAM + si latency
                if (rcnt <= RC_W'(1)) mem_addr_n = addr_inc(bus.mem_addr);
                if (rcnt == '0) begin
                    st_n  = RUN;
                    seg_n = '0;
                end else begin
                    rcnt_n = rcnt - RC_W'(1);
                end
            end
            RUN: begin
                mem_addr_n  = addr_inc(bus.mem_addr);
                seg_n       = addr_inc(seg);
                stop_pend_n = stop_pend | stop;
                if (seg == LAST && (stop_pend_n || limit_hit)) begin
                    st_n        = IDLE;
                    stop_pend_n = 1'b0;
                end
            end
            default: st_n = IDLE;
        endcase

        // Registered outputs follow the state being entered
        ld_ready_n   = (st_n == LOAD);
        fab_rst_n    = (st_n != RUN);
        si_n         = (st_n == RUN) ? bus.mem_rdata : '0;
        frame_sync_n = (st_n == RUN) && (seg_n == LAST);
        if (frame_sync_n) frame_cnt_n = frame_cnt + 16'd1;
    end
endmodule

// File: tb/tb_s4ga_cfg_sequencer.sv
// Scoreboard bench for s4ga_cfg_sequencer with an 8-segment frame and 5-cycle fabric reset.
module tb_s4ga_cfg_sequencer;
    localparam int unsigned SI_W = 4;
    localparam int unsigned FS   = 8;
    localparam int unsigned RC   = 5;
    localparam int unsigned A_W  = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic load_req = 1'b0, start = 1'b0, stop = 1'b0;
    logic [15:0] frame_limit = 16'd0;
    logic [SI_W-1:0] si;
    logic fab_rst, frame_sync, loaded, err;
    logic [1:0] state;
    logic [15:0] frame_cnt;

    s4ga_cfg_sequencer_if #(.SI_W(SI_W), .A_W(A_W)) bus ();

    s4ga_cfg_sequencer #(.SI_W(SI_W), .FRAME_SEGS(FS), .RST_CYCLES(RC), .A_W(A_W)) dut (
        .clk(clk), .rst(rst), .load_req(load_req), .start(start), .stop(stop),
`ifdef S4GA_SEQ_FRAMES_EN
        .frame_limit(frame_limit),
`endif
        .bus(bus), .si(si), .fab_rst(fab_rst), .frame_sync(frame_sync),
        .loaded(loaded), .err(err), .state(state), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    // External RAM: registered read, 1 cycle after address
    logic [SI_W-1:0] ram [FS];
    always @(posedge clk) begin
        if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_rdata <= ram[bus.mem_addr];
    end

    int n_checks = 0;
    int n_pass   = 0;
    logic [7:0]  wq [$];
    logic [31:0] sq [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Monitor: pops an expectation for every RAM write and every segment the fabric sees
    logic [7:0]  we_exp;
    logic [31:0] s_exp;
    always @(negedge clk) begin
        if (bus.mem_we) begin
            if (wq.size() == 0) begin
                n_checks++;
                $display("FAIL wr_unexpected: addr %0d data 0x%0h", bus.mem_addr, bus.mem_wdata);
            end else begin
                we_exp = wq.pop_front();
                chk("wr_addr", 32'(bus.mem_addr), 32'(we_exp[7:4]));
                chk("wr_data", 32'(bus.mem_wdata), 32'(we_exp[3:0]));
            end
        end
        if (!fab_rst) begin
            if (sq.size() == 0) begin
                n_checks++;
                $display("FAIL si_unexpected: si 0x%0h", si);
            end else begin
                s_exp = sq.pop_front();
                chk("si", 32'(si), 32'(s_exp[3:0]));
                chk("frame_sync", 32'(frame_sync), 32'(s_exp[4]));
                chk("frame_cnt", 32'(frame_cnt), 32'(s_exp[31:16]));
            end
        end
    end

    task automatic load_frame(input int nbeats, input int last_at, input logic [3:0] base, input int gap);
        bus.ld_valid = 1'b0; bus.ld_last = 1'b0; bus.ld_data = '0;
        load_req = 1'b1;
        @(negedge clk); load_req = 1'b0;
        chk("ld_ready_in_load", 32'(bus.ld_ready), 32'd1);
        for (int i = 0; i < nbeats; i++) begin
            repeat (gap) @(negedge clk);
            bus.ld_valid = 1'b1;
            bus.ld_data  = base + 4'(i);
            bus.ld_last  = (i == last_at - 1);
            wq.push_back({4'(i), base + 4'(i)});
            @(negedge clk);
            bus.ld_valid = 1'b0; bus.ld_last = 1'b0;
        end
        chk("ld_ready_drop", 32'(bus.ld_ready), 32'd0);
        chk("state_after_load", 32'(state), 32'd0);
    endtask

    // Push nseg expected segments (frame data 1..8), pulse start, check the reset hold length
    task automatic run_start(input int nseg);
        int frst;
        for (int i = 0; i < nseg; i++)
            sq.push_back({16'((i + 1) / FS), 11'd0, 1'((i % FS) == FS - 1), 4'((i % FS) + 1)});
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        frst = 0;
        while (state == 2'd2 && fab_rst && frst < 30) begin
            frst++;
            @(negedge clk);
        end
        chk("frst_cycles", 32'(frst), 32'(RC));
        chk("state_run", 32'(state), 32'd3);
    endtask

    task automatic wait_drain(input int budget);
        int g = 0;
        while ((sq.size() != 0 || wq.size() != 0) && g < budget) begin
            @(negedge clk); g++;
        end
        chk("drain_in_time", 32'(sq.size() + wq.size()), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        int g;
        bus.ld_valid = 1'b0; bus.ld_last = 1'b0; bus.ld_data = '0;

        // 1. reset
        repeat (2) @(negedge clk);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_fab_rst", 32'(fab_rst), 32'd1);
        chk("rst_ld_ready", 32'(bus.ld_ready), 32'd0);
        chk("rst_si", 32'(si), 32'd0);
        chk("rst_loaded", 32'(loaded), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // 2. good load 1..8
        load_frame(8, 8, 4'h1, 0);
        @(negedge clk);
        chk("loaded_ok", 32'(loaded), 32'd1);
        chk("err_clean", 32'(err), 32'd0);

        // 3/4. run, stop while si=3 in frame 2 -> 16 segments
        run_start(16);
        g = 0;
        while (!(si == 4'd3 && frame_cnt == 16'd1 && !fab_rst) && g < 100) begin
            @(negedge clk); g++;
        end
        chk("saw_si3", 32'(g < 100), 32'd1);
        stop = 1'b1;
        @(negedge clk); stop = 1'b0;
        wait_drain(40);
        chk("stop_idle", 32'(state), 32'd0);
        chk("stop_fab_rst", 32'(fab_rst), 32'd1);
        chk("stop_si_zero", 32'(si), 32'd0);

        // 5. short load -> err, then start refused
        load_frame(5, 5, 4'hA, 0);
        @(negedge clk);
        chk("short_err", 32'(err), 32'd1);
        chk("short_loaded", 32'(loaded), 32'd0);
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(negedge clk);
        chk("start_unloaded_state", 32'(state), 32'd0);
        chk("start_unloaded_err", 32'(err), 32'd1);
        chk("start_unloaded_fab", 32'(fab_rst), 32'd1);

        // gapped reload restores the frame image
        load_frame(8, 8, 4'h1, 2);
        @(negedge clk);
        chk("gap_loaded", 32'(loaded), 32'd1);
        for (int i = 0; i < 8; i++) chk("ram_image", 32'(ram[i]), 32'(i + 1));

        // single frame run: stop in the first RUN cycle
        run_start(8);
        stop = 1'b1;
        @(negedge clk); stop = 1'b0;
        wait_drain(40);
        chk("one_frame_idle", 32'(state), 32'd0);
        chk("one_frame_cnt", 32'(frame_cnt), 32'd1);

`ifdef S4GA_SEQ_FRAMES_EN
        frame_limit = 16'd2;
        run_start(16);
        wait_drain(60);
        chk("limit_idle", 32'(state), 32'd0);
        chk("limit_fab_rst", 32'(fab_rst), 32'd1);
        frame_limit = 16'd0;
`endif

        // 6. rst mid-run at si=4
        run_start(4);
        g = 0;
        while (!(si == 4'd4 && !fab_rst) && g < 40) begin
            @(negedge clk); g++;
        end
        chk("saw_si4", 32'(g < 40), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_state", 32'(state), 32'd0);
        chk("midrst_fab_rst", 32'(fab_rst), 32'd1);
        chk("midrst_loaded", 32'(loaded), 32'd0);
        chk("midrst_si", 32'(si), 32'd0);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("queues_empty", 32'(sq.size() + wq.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d passed", n_pass, n_checks);
        $fatal(1);
    end
endmodule
